// File: rtl/video_in_store.sv
// Drains packed pixel words from an FWFT FIFO into the frame buffer as Wishbone incrementing bursts.
// Optional double buffering: define VIDEO_IN_STORE_DOUBLE_BUF_EN to alternate buf_base0/buf_base1 per frame.
module video_in_store #(
    parameter int P_WIDTH   = 640,
    parameter int P_HEIGHT  = 480,
    parameter int P_BURST   = 8,
    parameter int P_LEVEL_W = 6
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 enable,
    input  logic [31:0]          buf_base0,
    input  logic [31:0]          buf_base1,
    input  logic [31:0]          fifo_data,
    input  logic [P_LEVEL_W-1:0] fifo_level,
    output logic                 fifo_rd,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic [2:0]           wb_cti_o,
    output logic [1:0]           wb_bte_o,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    output logic                 frame_done,
    output logic                 cur_buf,
    output logic                 err
);

    localparam int N      = P_WIDTH * P_HEIGHT / 4;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int BEAT_W = (P_BURST > 1) ? $clog2(P_BURST) : 1;

    localparam logic [CNT_W-1:0]     LAST_WORD = CNT_W'(N - 1);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(P_BURST - 1);
    localparam logic [P_LEVEL_W-1:0] BURST_LVL = P_LEVEL_W'(P_BURST);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        FEND,
        ERR
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   word_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               beat_ack;
    logic               last_beat;
    logic [31:0]        base;
    logic [31:0]        word_off;

    // Error outranks ack: an errored beat is never popped or counted.
    assign beat_ack  = (state == BURST) && wb_ack_i && !wb_err_i;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign word_off  = 32'(word_cnt) << 2;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if ((word_cnt != '0 || enable) && fifo_level >= BURST_LVL) begin
                    state_nx = BURST;
                end
            end
            BURST: begin
                if (wb_err_i) begin
                    state_nx = ERR;
                end else if (wb_ack_i && last_beat) begin
                    state_nx = (word_cnt == LAST_WORD) ? FEND : IDLE;
                end
            end
            FEND:    state_nx = IDLE;
            ERR:     state_nx = ERR;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            word_cnt <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (beat_ack) begin
                word_cnt <= word_cnt + 1'b1;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end else if (state == FEND) begin
                word_cnt <= '0;
            end
            if (state == BURST && wb_err_i) begin
                err <= 1'b1;
            end
        end
    end

`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cur_buf <= 1'b0;
        end else if (state == FEND) begin
            cur_buf <= ~cur_buf;
        end
    end

    assign base = cur_buf ? buf_base1 : buf_base0;
`else
    logic unused_buf_base1;

    assign unused_buf_base1 = ^buf_base1;
    assign cur_buf          = 1'b0;
    assign base             = buf_base0;
`endif

    always_comb begin
        fifo_rd    = 1'b0;
        wb_adr_o   = '0;
        wb_dat_o   = '0;
        wb_sel_o   = '0;
        wb_we_o    = 1'b0;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        wb_cti_o   = '0;
        wb_bte_o   = '0;
        frame_done = 1'b0;
        case (state)
            BURST: begin
                fifo_rd  = beat_ack;
                wb_adr_o = base + word_off;
                wb_dat_o = fifo_data;
                wb_sel_o = '1;
                wb_we_o  = 1'b1;
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_cti_o = last_beat ? 3'b111 : 3'b010;
                wb_bte_o = 2'b00;
            end
            FEND:    frame_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_video_in_store.sv
// Scoreboard bench for video_in_store: stimulus queues expected beats/frame ends, a monitor checks them.
module tb_video_in_store;

    localparam int P_LEVEL_W = 6;

`ifdef VIDEO_IN_STORE_DOUBLE_BUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h0000_2000;
    localparam logic [31:0] BASE_F1 = DBUF ? BASE1 : BASE0;
    localparam logic [31:0] DWORD = 32'hD000_0000;

    logic                 clk;
    logic                 nRST;
    logic                 enable;
    logic [31:0]          fifo_data;
    logic [P_LEVEL_W-1:0] fifo_level;
    logic                 fifo_rd;
    logic [31:0]          wb_adr_o;
    logic [31:0]          wb_dat_o;
    logic [3:0]           wb_sel_o;
    logic                 wb_we_o;
    logic                 wb_cyc_o;
    logic                 wb_stb_o;
    logic [2:0]           wb_cti_o;
    logic [1:0]           wb_bte_o;
    logic                 wb_ack_i;
    logic                 wb_err_i;
    logic                 frame_done;
    logic                 cur_buf;
    logic                 err;

    video_in_store #(
        .P_WIDTH   (16),
        .P_HEIGHT  (2),
        .P_BURST   (4),
        .P_LEVEL_W (P_LEVEL_W)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .enable     (enable),
        .buf_base0  (BASE0),
        .buf_base1  (BASE1),
        .fifo_data  (fifo_data),
        .fifo_level (fifo_level),
        .fifo_rd    (fifo_rd),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .frame_done (frame_done),
        .cur_buf    (cur_buf),
        .err        (err)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    beat_t exp_q[$];
    logic  done_q[$];

    int checks = 0;
    int errors = 0;
    int total_pushed = 0;
    int total_popped = 0;
    int exp_word = 0;
    int wait_states = 0;
    int err_at = -1;
    int wcnt = 0;
    int beat_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FIFO model: word k carries DWORD + k.
    assign fifo_level = P_LEVEL_W'(total_pushed - total_popped);
    assign fifo_data  = DWORD + 32'(total_popped);

    always @(posedge clk) begin
        if (fifo_rd) total_popped <= total_popped + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Slave: decides ack/err for the coming edge, with wait_states idle cycles per beat.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (!nRST) begin
            wcnt    = 0;
            beat_no = 0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (wcnt >= wait_states) begin
                if (beat_no == err_at) wb_err_i = 1'b1;
                else                   wb_ack_i = 1'b1;
                beat_no++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        #1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_beat: got adr %h, expected no beat", wb_adr_o);
            end else begin
                e = exp_q.pop_front();
                chk("adr", wb_adr_o, e.adr);
                chk("dat", wb_dat_o, e.dat);
                chk("cti", 32'(wb_cti_o), 32'(e.cti));
                chk("ack_rd", 32'(fifo_rd), 32'd1);
                chk("sel", 32'(wb_sel_o), 32'hF);
                chk("we", 32'(wb_we_o), 32'd1);
            end
        end else if (wb_cyc_o && wb_stb_o) begin
            chk("wait_rd", 32'(fifo_rd), 32'd0);
            if (exp_q.size() != 0) begin
                chk("hold_adr", wb_adr_o, exp_q[0].adr);
                chk("hold_dat", wb_dat_o, exp_q[0].dat);
            end
        end else begin
            chk("idle_rd", 32'(fifo_rd), 32'd0);
        end
        if (frame_done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got frame_done=1, expected 0");
            end else begin
                chk("done_buf", 32'(cur_buf), 32'(done_q.pop_front()));
            end
        end
    end

    task automatic push_burst(input logic [31:0] adr0);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.adr = adr0 + 32'(4 * i);
            b.dat = DWORD + 32'(exp_word);
            b.cti = (i == 3) ? 3'b111 : 3'b010;
            exp_q.push_back(b);
            exp_word++;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_left", 32'(exp_q.size() + done_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        total_pushed = total_popped;
        #1;
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_buf", 32'(cur_buf), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        nRST = 1'b1;
    endtask

    initial begin
        int snap;
        bit seen;
        nRST     = 1'b0;
        enable   = 1'b0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        @(negedge clk);

        // Two full frames, ack every cycle
        do_reset();
        enable = 1'b1;
        push_burst(BASE0);
        push_burst(BASE0 + 32'h10);
        done_q.push_back(1'b0);
        total_pushed += 8;
        wait_drain(100);
        repeat (2) @(negedge clk);
        #1 chk("buf_after_f0", 32'(cur_buf), 32'(DBUF));
        push_burst(BASE_F1);
        push_burst(BASE_F1 + 32'h10);
        done_q.push_back(DBUF);
        total_pushed += 8;
        wait_drain(100);
        repeat (2) @(negedge clk);
        #1 chk("buf_after_f1", 32'(cur_buf), 32'd0);

        // Two wait cycles per beat
        do_reset();
        wait_states = 2;
        snap = total_popped;
        push_burst(BASE0);
        push_burst(BASE0 + 32'h10);
        done_q.push_back(1'b0);
        total_pushed += 8;
        wait_drain(200);
        repeat (2) @(negedge clk);
        chk("wait_pops", 32'(total_popped - snap), 32'd8);
        wait_states = 0;

        // Level below burst size holds off the bus
        do_reset();
        total_pushed += 3;
        repeat (5) @(negedge clk);
        #1 chk("low_level_cyc", 32'(wb_cyc_o), 32'd0);
        push_burst(BASE0);
        @(negedge clk);
        total_pushed += 1;
        @(negedge clk);
        #1 chk("level4_cyc", 32'(wb_cyc_o), 32'd1);
        wait_drain(100);
        push_burst(BASE0 + 32'h10);
        done_q.push_back(1'b0);
        total_pushed += 4;
        wait_drain(100);

        // Enable drop mid-frame: frame completes, then bus stays quiet
        do_reset();
        push_burst(BASE0);
        total_pushed += 4;
        wait_drain(100);
        enable = 1'b0;
        push_burst(BASE0 + 32'h10);
        done_q.push_back(1'b0);
        total_pushed += 4;
        wait_drain(100);
        repeat (2) @(negedge clk);
        total_pushed += 8;
        snap = total_popped;
        repeat (20) @(negedge clk);
        #1 chk("disabled_cyc", 32'(wb_cyc_o), 32'd0);
        chk("disabled_pops", 32'(total_popped - snap), 32'd0);

        // Bus error on the second beat
        do_reset();
        enable = 1'b1;
        err_at = 1;
        snap = total_popped;
        begin
            beat_t b;
            b.adr = BASE0;
            b.dat = DWORD + 32'(exp_word);
            b.cti = 3'b010;
            exp_q.push_back(b);
            exp_word++;
        end
        total_pushed += 8;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (wb_err_i && wb_cyc_o) seen = 1'b1;
        end
        chk("err_seen", 32'(seen), 32'd1);
        @(negedge clk);
        #1 chk("err_cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("err_flag", 32'(err), 32'd1);
        repeat (10) @(negedge clk);
        #1 chk("err_sticky", 32'(err), 32'd1);
        chk("err_quiet", 32'(wb_cyc_o), 32'd0);
        chk("err_pops", 32'(total_popped - snap), 32'd1);
        chk("err_q_empty", 32'(exp_q.size()), 32'd0);
        err_at = -1;

        // Reset while a burst is in flight
        do_reset();
        wait_states = 1000;
        total_pushed += 8;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (wb_cyc_o) seen = 1'b1;
        end
        chk("pre_rst_cyc", 32'(seen), 32'd1);
        nRST = 1'b0;
        #1;
        chk("async_cyc", 32'(wb_cyc_o), 32'd0);
        chk("async_stb", 32'(wb_stb_o), 32'd0);
        wait_states = 0;
        do_reset();
        push_burst(BASE0);
        push_burst(BASE0 + 32'h10);
        done_q.push_back(1'b0);
        total_pushed += 8;
        wait_drain(100);
        repeat (2) @(negedge clk);
        #1 chk("rst_buf_f0", 32'(cur_buf), 32'(DBUF));
        push_burst(BASE_F1);
        push_burst(BASE_F1 + 32'h10);
        done_q.push_back(DBUF);
        total_pushed += 8;
        wait_drain(100);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/video_in_store.md
Name: video_in_store

Overview:
Downstream of the video_in pixel packer and its word FIFO. Drains packed 32-bit pixel words (4 pixels/word) from a first-word-fall-through FIFO and writes them to the frame buffer in memory as Wishbone incrementing bursts. Tracks the word position within the frame, flips between two frame-buffer bases at each frame end, and pulses frame_done for the processing side.

Parameters:
P_WIDTH, 640, pixels per line
P_HEIGHT, 480, lines per frame
P_BURST, 8, words per Wishbone burst; P_WIDTH*P_HEIGHT/4 must be a multiple of P_BURST
P_LEVEL_W, 6, width of FIFO fill-level input

Ports:
clk  in  1  system clock
nRST  in  1  asynchronous active-low reset
enable  in  1  capture enable, sampled only in IDLE at a frame boundary
buf_base0  in  32  byte address of frame buffer 0 (word aligned)
buf_base1  in  32  byte address of frame buffer 1 (word aligned)
fifo_data  in  32  FWFT head word, valid while fifo_level != 0
fifo_level  in  P_LEVEL_W  number of words in FIFO
fifo_rd  out  1  pop head word this cycle
wb_adr_o  out  32  byte address
wb_dat_o  out  32  write data, equals fifo_data
wb_sel_o  out  4  constant 4'b1111
wb_we_o  out  1  constant 1 while wb_cyc_o
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  3'b010 incrementing, 3'b111 last beat
wb_bte_o  out  2  constant 2'b00 linear
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
frame_done  out  1  one-cycle pulse after the last word of a frame is acked
cur_buf  out  1  index of buffer currently being written
err  out  1  sticky bus-error flag

Behaviour:
- Reset (async): state IDLE, word_cnt=0, beat_cnt=0, cur_buf=0, err=0. All Wishbone outputs, fifo_rd and frame_done are 0.
- Frame length N = P_WIDTH*P_HEIGHT/4 words. word_cnt has width ceil(log2(N+1)).
- IDLE: if word_cnt==0 and !enable, stay in IDLE. Otherwise, if fifo_level >= P_BURST, go to BURST next cycle. Any enable change mid-frame is ignored; the current frame always completes.
- BURST: wb_cyc_o=wb_stb_o=1.
  - wb_adr_o = base(cur_buf) + 4*word_cnt.
  - wb_dat_o = fifo_data.
  - fifo_rd = wb_ack_i; exactly one pop per ack. Data and address stay stable while ack is low.
  - On each ack: word_cnt++, beat_cnt++.
  - wb_cti_o = 3'b111 when beat_cnt == P_BURST-1, else 3'b010.
  - On the ack of the last beat: cyc/stb drop the next cycle, beat_cnt=0. Go to FEND if word_cnt+1==N, else IDLE.
  - Minimum of one idle cycle between bursts.
- FEND: frame_done=1 for one cycle, word_cnt=0, cur_buf toggles; go to IDLE.
- wb_err_i during BURST (takes priority over ack): no pop, cyc/stb drop next cycle, err=1, go to ERR. ERR holds all bus outputs at 0 and holds err until reset.
- The FIFO never underflows: a burst starts only when level >= P_BURST. A FIFO overflow is the packer's concern and is not detected here.
- Simultaneous ack and last beat of frame: the pop, count and transition to FEND occur in the same cycle.
- Reset mid-burst: cyc/stb drop asynchronously. Popped words are lost; the next frame restarts at word 0 of buffer 0.

Optional Feature:
VIDEO_IN_STORE_DOUBLE_BUF_EN:
- Defined: buffers alternate as above; base(cur_buf) selects buf_base0 or buf_base1.
- Undefined: buf_base1 is ignored, cur_buf is tied to 0, and every frame is written at buf_base0. The toggle logic is absent.

Test Plan:
1. P_WIDTH=16, P_HEIGHT=2, P_BURST=4, double-buf enabled, base0=0x1000, base1=0x2000, FIFO preloaded with 8 words, ack every cycle, enable=1. Expect 2 bursts at 0x1000..0x100C and 0x1010..0x101C; cti 010,010,010,111 per burst; frame_done pulse once; cur_buf becomes 1. Second frame targets 0x2000.
2. Same setup with ack inserting 2 wait cycles per beat. Expect wb_adr_o and wb_dat_o held stable, fifo_rd high only on ack cycles, exactly 8 pops total.
3. fifo_level held at 3 (< P_BURST). Expect no cyc. Raise to 4: cyc asserts on the next cycle.
4. Deassert enable after the first burst. Expect the frame to complete and frame_done to pulse. No further bursts while enable=0, even with fifo_level=8.
5. wb_err_i on beat 2 of the first burst. Expect err=1, cyc dropped next cycle, only 1 pop counted, no further bus activity until nRST.
6. Assert nRST low mid-burst. Expect cyc/stb=0 immediately. After release, the first burst addresses 0x1000 and cur_buf=0. With double-buf undefined, the second frame also targets 0x1000.
